// File: rtl/single_port_ram_bidir.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : single_port_ram_bidir
// Brief    : Sync-write / async-read single-port RAM on a shared tri-state bus.
//            Optional per-word even parity when SPRAM_PARITY_EN is defined.
// Revision : 1.0
// ---------------------------------------------------------------------------
module single_port_ram_bidir #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  re,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  inout  wire  [DATA_WIDTH-1:0] data,
  output logic                  conflict,
  output logic                  parity_err
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  drive_en;
  logic                  write_en;

  // The RAM only owns the bus for a clean read; reset and collisions float it.
  assign drive_en = !rst && re && !we;
  assign write_en = we && !re;
  assign data     = drive_en ? mem[addr] : {DATA_WIDTH{1'bz}};

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      conflict <= 1'b0;
    end else begin
      conflict <= re && we;
      if (write_en) begin
        mem[addr] <= data;
      end
    end
  end

`ifdef SPRAM_PARITY_EN
  logic par_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        par_mem[i] <= 1'b0;
      end
    end else if (write_en) begin
      par_mem[addr] <= ^data;
    end
  end

  assign parity_err = drive_en && ((^mem[addr]) != par_mem[addr]);
`else
  assign parity_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_single_port_ram_bidir.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_single_port_ram_bidir
// Brief    : Directed scoreboard bench for single_port_ram_bidir; the bus is
//            pulled up so a floating RAM reads back as all-ones.
// Revision : 1.0
// ---------------------------------------------------------------------------
module tb_single_port_ram_bidir;

  localparam int DW = 16;
  localparam int AW = 3;
  localparam int K_DATA = 0;
  localparam int K_CONF = 1;
  localparam int K_PERR = 2;
  localparam logic [DW-1:0] FLOAT = 16'hFFFF;

  logic          clk = 1'b0;
  logic          rst;
  logic          re;
  logic          we;
  logic [AW-1:0] addr;
  wire  [DW-1:0] data;
  logic          conflict;
  logic          parity_err;
  logic          drv_en;
  logic [DW-1:0] drv_val;

  typedef struct {
    string         name;
    int            kind;
    logic [DW-1:0] exp;
  } exp_t;

  exp_t q[$];
  event ev_push;
  int   checks = 0;
  int   errors = 0;

  assign data = drv_en ? drv_val : {DW{1'bz}};

  for (genvar g = 0; g < DW; g++) begin : g_pull
    pullup (data[g]);
  end

  single_port_ram_bidir #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .re         (re),
    .we         (we),
    .addr       (addr),
    .data       (data),
    .conflict   (conflict),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  // Monitor: drains the scoreboard whenever stimulus announces a settled output.
  initial begin
    exp_t          e;
    logic [DW-1:0] act;
    forever begin
      @(ev_push);
      while (q.size() > 0) begin
        e = q.pop_front();
        case (e.kind)
          K_CONF:  act = {{(DW-1){1'b0}}, conflict};
          K_PERR:  act = {{(DW-1){1'b0}}, parity_err};
          default: act = data;
        endcase
        checks++;
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
        end
      end
    end
  end

  task automatic expect_out(input string name, input int kind, input logic [DW-1:0] val);
    exp_t e;
    #1;
    e.name = name;
    e.kind = kind;
    e.exp  = val;
    q.push_back(e);
    ->ev_push;
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] v);
    we = 1'b1; re = 1'b0; addr = a; drv_val = v; drv_en = 1'b1;
    @(posedge clk); #1;
    we = 1'b0; drv_en = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; re = 1'b1; we = 1'b0; addr = '0; drv_en = 1'b0; drv_val = '0;
    tick();
    expect_out("rst_float", K_DATA, FLOAT);
    tick();
    expect_out("rst_conflict", K_CONF, 16'h0);
    rst = 1'b0;

    // Cleared memory reads zero everywhere.
    for (int i = 0; i < 8; i++) begin
      addr = AW'(i);
      expect_out($sformatf("zero_rd%0d", i), K_DATA, 16'h0000);
    end
    expect_out("zero_conflict", K_CONF, 16'h0);
    expect_out("zero_perr", K_PERR, 16'h0);

    do_write(3'd3, 16'hA5A5);
    re = 1'b1; addr = 3'd3;
    expect_out("rd3_a5a5", K_DATA, 16'hA5A5);
    addr = 3'd4;
    expect_out("rd4_zero", K_DATA, 16'h0000);
    re = 1'b0;
    expect_out("idle_float", K_DATA, FLOAT);

    for (int i = 0; i < 8; i++) begin
      do_write(AW'(i), DW'(i * 16'h1111));
    end
    re = 1'b1;
    for (int i = 0; i < 8; i++) begin
      addr = AW'(i);
      expect_out($sformatf("pat_rd%0d", i), K_DATA, DW'(i * 16'h1111));
    end
    re = 1'b0;

    // Collision: bus must float and the write must be dropped.
    do_write(3'd2, 16'h1234);
    re = 1'b1; we = 1'b1; addr = 3'd2;
    expect_out("coll_float", K_DATA, FLOAT);
    drv_val = 16'hFFFF; drv_en = 1'b1;
    tick();
    expect_out("coll_conflict_hi", K_CONF, 16'h1);
    re = 1'b0; we = 1'b0; drv_en = 1'b0;
    tick();
    expect_out("coll_conflict_lo", K_CONF, 16'h0);
    re = 1'b1; addr = 3'd2;
    expect_out("coll_kept", K_DATA, 16'h1234);
    re = 1'b0;

    // Reset beats a simultaneous write; bus floats while in reset.
    rst = 1'b1; we = 1'b1; addr = 3'd1; drv_val = 16'hBEEF; drv_en = 1'b1;
    tick();
    we = 1'b0; drv_en = 1'b0; re = 1'b1;
    expect_out("rst_rd_float", K_DATA, FLOAT);
    rst = 1'b0;
    expect_out("rst_wr_lost", K_DATA, 16'h0000);
    addr = 3'd7;
    expect_out("rst_cleared7", K_DATA, 16'h0000);
    re = 1'b0;

`ifdef SPRAM_PARITY_EN
    do_write(3'd6, 16'h0001);
    do_write(3'd5, 16'h0003);
    re = 1'b1; addr = 3'd6;
    expect_out("perr_clean", K_PERR, 16'h0);
    dut.mem[6] = 16'h0003;
    expect_out("perr_flip", K_PERR, 16'h1);
    addr = 3'd5;
    expect_out("perr_other", K_PERR, 16'h0);
    re = 1'b0;
`endif

    #2;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/single_port_ram_bidir.md
Name: single_port_ram_bidir

Overview:
Synchronous-write, asynchronous-read single-port RAM. Default geometry is 8 words x 16 bits. Data moves over one shared tri-state bus: the external master drives it for writes, and the RAM drives it for reads. The block sits as a small register-file/scratch memory behind a simple re/we strobe interface.

Parameters:
- DATA_WIDTH, 16, width of each word and of the data bus.
- ADDR_WIDTH, 3, address width; DEPTH = 2**ADDR_WIDTH (default 8).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- re  input  1  read enable.
- we  input  1  write enable.
- addr  input  ADDR_WIDTH  word address.
- data  inout  DATA_WIDTH  shared bidirectional data bus.
- conflict  output  1  registered flag: re and we were both high at the previous edge.
- parity_err  output  1  read parity mismatch (see Optional Feature).

Behaviour:
- Memory array: DEPTH x DATA_WIDTH registers.
- Reset (rst=1 at rising edge):
  - all DEPTH words cleared to 0; conflict <= 0.
  - writes are ignored during that cycle.
  - while rst=1 the RAM does not drive data (high-Z), regardless of re/we.
- Write, at a rising edge with rst=0, we=1, re=0:
  - mem[addr] <= data, using the value the master drives on the bus.
  - the RAM itself never drives the bus during a write.
  - the write is visible to a read in the following cycle.
- Read, when rst=0, re=1, we=0:
  - the RAM drives data with mem[addr] combinationally (zero-cycle latency).
  - a change of addr updates data in the same cycle.
  - no clock edge is needed for the read.
- Idle, re=0 and we=0: data is high-Z; memory unchanged.
- Collision, re=1 and we=1:
  - treated as illegal; no write occurs and data is high-Z.
  - conflict <= 1 at that edge; conflict <= 0 at any later edge where the condition is absent.
  - conflict is a one-cycle pulse per colliding cycle, not sticky.
- Bus drive rule: data enable = !rst && re && !we. At every other time the RAM presents high-Z on data.
- Address: all 2**ADDR_WIDTH addresses are valid; there is no out-of-range case.
- X/Z on the bus during a write is stored as-is; no filtering.
- Reset mid-operation: a reset in the same cycle as a write wins; the word stays 0.

Optional Feature:
- Macro: SPRAM_PARITY_EN
- Defined:
  - each word stores one extra even-parity bit computed from the bus value at write time.
  - on reset, stored parity is cleared to 0, which is consistent with zero data.
  - during a read, parity_err = 1 when the recomputed parity of mem[addr] differs from the stored bit; the output is combinational and valid only while the bus is driven, else 0.
- Not defined:
  - no parity storage; parity_err tied to 0.
  - port list is identical either way.

Test Plan:
- Reset, then rst=0; re=1 on addr 0..7 -> data = 0x0000 at every address; conflict = 0.
- we=1, addr=3, bus driven 0xA5A5 for one edge; then we=0, re=1, addr=3 -> data = 0xA5A5; addr=4 -> 0x0000.
- Write addr i with value i*0x1111 for i=0..7 (one edge each); then read 0..7 with no clock between address changes -> 0x0000, 0x1111, ..., 0x7777, each in the same cycle as the address change.
- Pre-load addr 2 = 0x1234; assert re=1, we=1, master drives 0xFFFF on addr 2 for one edge -> data high-Z from the RAM, conflict = 1 for exactly one cycle, later read of addr 2 = 0x1234.
- Assert rst with we=1, addr=1, bus 0xBEEF; release rst; read addr 1 -> 0x0000; data is high-Z while rst=1 even with re=1.
- SPRAM_PARITY_EN: write 0x0001 to addr 6, force-flip a stored data bit, read addr 6 -> parity_err = 1; an unmodified word gives parity_err = 0.
